ysyx_25010008_prefetch_ifu: RTL and testbench

//  Parametrised prefetching instruction fetch unit. Fetches sequential words from

---
 rtl/ysyx_25010008_prefetch_ifu.sv | 173 +++++++++++++++++
 tb/tb_ysyx_25010008_prefetch_ifu.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25010008_prefetch_ifu.sv
// Prefetching IFU: sequential word fetches over an AR/R pair into a small FIFO drained by the IDU.
// Optional: define YSYX_IFU_PERF_EN to add the perf_fetch_cnt/perf_stall_cnt/perf_flush_cnt outputs.
module ysyx_25010008_prefetch_ifu #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h3000_0000,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            ifault,
  output logic            ivalid,
  input  logic            iready,
  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready
`ifdef YSYX_IFU_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_BOOT, S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_HALT
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            fault;
  } entry_t;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   hold_addr_q, hold_addr_d;
  logic              pending_q, pending_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_pop, count_push;
  entry_t            mem [FIFO_DEPTH];
  entry_t            head;
  logic              push, pop;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // A redirect voids both the pop and the push of its cycle.
  assign ivalid     = (count_q != '0);
  assign pop        = ivalid && iready && !redirect;
  assign push       = (state_q == S_DATA) && rvalid && !redirect;
  assign count_pop  = count_q - CNT_W'(pop);
  assign count_push = count_pop + CNT_W'(push);

  assign head    = mem[rd_ptr_q];
  assign inst    = ivalid ? head.inst  : '0;
  assign inst_pc = ivalid ? head.pc    : '0;
  assign ifault  = ivalid ? head.fault : 1'b0;

  // While a flushed request is still waiting for arready, the old address stays on the bus.
  assign arvalid = (state_q == S_ADDR);
  assign araddr  = pending_q ? hold_addr_q : fetch_pc_q;
  assign rready  = (state_q == S_DATA) || (state_q == S_DRAIN);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    hold_addr_d = hold_addr_q;
    pending_d   = pending_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      unique case (state_q)
        S_ADDR: begin
          if (arready) begin
            state_d   = S_DRAIN;
            pending_d = 1'b0;
          end else begin
            pending_d = 1'b1;
            if (!pending_q) hold_addr_d = fetch_pc_q;
          end
        end
        S_DATA, S_DRAIN: state_d = rvalid ? S_ADDR : S_DRAIN;
        default:         state_d = S_ADDR;
      endcase
    end else begin
      unique case (state_q)
        S_BOOT: state_d = S_ADDR;
        S_IDLE: if (count_pop < DEPTH_C) state_d = S_ADDR;
        S_ADDR: begin
          if (arready) begin
            state_d   = pending_q ? S_DRAIN : S_DATA;
            pending_d = 1'b0;
          end
        end
        S_DATA: begin
          if (rvalid) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (rresp != 2'b00)           state_d = S_HALT;
            else if (count_push < DEPTH_C) state_d = S_ADDR;
            else                           state_d = S_IDLE;
          end
        end
        S_DRAIN: if (rvalid) state_d = S_ADDR;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= S_BOOT;
      fetch_pc_q  <= RESET_PC;
      hold_addr_q <= '0;
      pending_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      hold_addr_q <= hold_addr_d;
      pending_q   <= pending_d;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_push;
      end
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= '{pc: fetch_pc_q, inst: rdata, fault: (rresp != 2'b00)};
  end

`ifdef YSYX_IFU_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q, perf_flush_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (push)     perf_fetch_q <= perf_fetch_q + 32'd1;
      if (!ivalid)  perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_ysyx_25010008_prefetch_ifu.sv
// Bench for the prefetching IFU: AR/R responder model, IDU-side scoreboard and redirect vector table.
module tb_ysyx_25010008_prefetch_ifu;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        reset, redirect, iready;
  logic [31:0] redirect_pc;
  logic [31:0] inst, inst_pc, araddr, rdata;
  logic        ifault, ivalid, arvalid, arready, rvalid, rready;
  logic [1:0]  rresp;
`ifdef YSYX_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  ysyx_25010008_prefetch_ifu dut (
    .clock       (clock),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .ifault      (ifault),
    .ivalid      (ivalid),
    .iready      (iready),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready)
`ifdef YSYX_IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  typedef enum {PH_DATA, PH_RBEAT} phase_e;

  typedef struct {
    phase_e      phase;
    logic [31:0] rd_pc;
    logic [31:0] exp_pc;
    int          n;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  exp_t        exp_q[$];
  logic [31:0] ar_log[$];
  int          r_lat      = 0;
  logic        ar_stall   = 1'b0;
  logic [31:0] fault_addr = 32'h0000_0001;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Drive/observe slot of the main process: two time units after the falling edge.
  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  task automatic expect_from(input logic [31:0] pc, input int n);
    exp_t        e;
    logic [31:0] p;
    p = pc;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      e.pc    = p;
      e.inst  = hash(p);
      e.fault = (p == fault_addr);
      exp_q.push_back(e);
      p = p + 32'd4;
    end
  endtask

  task automatic wait_pops(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (pops < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(pops >= target), 32'd1);
  endtask

  // Memory-side responder: one request at a time, R beat r_lat cycles after AR, data = hash(addr).
  initial begin : slave
    logic        busy, ar_hs, r_hs;
    logic [31:0] addr, ar_addr_s;
    int          wait_c;
    busy = 1'b0; ar_hs = 1'b0; r_hs = 1'b0; addr = '0; ar_addr_s = '0; wait_c = 0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        busy = 1'b0; ar_hs = 1'b0; r_hs = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      end else begin
        if (r_hs) begin
          busy   = 1'b0;
          rvalid = 1'b0;
        end
        if (ar_hs) begin
          busy   = 1'b1;
          addr   = ar_addr_s;
          wait_c = r_lat;
          ar_log.push_back(ar_addr_s);
        end
        if (busy && !rvalid) begin
          if (wait_c == 0) begin
            rvalid = 1'b1;
            rdata  = hash(addr);
            rresp  = (addr == fault_addr) ? 2'b10 : 2'b00;
          end else begin
            wait_c--;
          end
        end
        arready   = !busy && !ar_stall;
        ar_hs     = arvalid && arready;
        ar_addr_s = araddr;
        r_hs      = rvalid && rready;
      end
    end
  end

  // IDU-side scoreboard: every accepted head entry is compared against the expectation queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (!reset && ivalid && iready && !redirect) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got entry pc %h, required no entry", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", inst_pc, e.pc);
          check("pop_inst", inst, e.inst);
          check_bit("pop_fault", ifault, e.fault);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin : main
    vec_t        vecs[4];
    int          base, p0, a0, idx, n;
    logic        hit;

    vecs[0] = '{phase: PH_DATA,  rd_pc: 32'h8000_0002, exp_pc: 32'h8000_0000, n: 3};
    vecs[1] = '{phase: PH_RBEAT, rd_pc: 32'h0000_0013, exp_pc: 32'h0000_0010, n: 3};
    vecs[2] = '{phase: PH_DATA,  rd_pc: 32'hFFFF_FFF9, exp_pc: 32'hFFFF_FFF8, n: 4};
    vecs[3] = '{phase: PH_RBEAT, rd_pc: 32'h1234_5678, exp_pc: 32'h1234_5678, n: 2};

    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; iready = 1'b0;
    tick();
    tick();

    // Reset state
    check_bit("rst_arvalid", arvalid, 1'b0);
    check_bit("rst_rready", rready, 1'b0);
    check_bit("rst_ivalid", ivalid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check_bit("rst_ifault", ifault, 1'b0);

    // Streaming from RESET_PC with the IDU always ready
    iready = 1'b1;
    base   = ar_log.size();
    p0     = pops;
    expect_from(RESET_PC, 40);
    reset = 1'b0;
    tick();
    check_bit("boot_arvalid", arvalid, 1'b1);
    check("boot_araddr", araddr, RESET_PC);
    wait_pops(p0 + 8, 100, "s1_pops");
    check("s1_ar_count", 32'(ar_log.size() >= base + 8), 32'd1);
    if (ar_log.size() >= base + 8)
      for (int k = 0; k < 8; k++) check("s1_araddr", ar_log[base + k], RESET_PC + 32'(4 * k));

    // Backpressure: FIFO fills to exactly FIFO_DEPTH and fetching stops
    iready = 1'b0;
    repeat (20) tick();
    check_bit("s2_ivalid", ivalid, 1'b1);
    check_bit("s2_arvalid", arvalid, 1'b0);
    check_bit("s2_rready", rready, 1'b0);
    check("s2_fill", 32'((ar_log.size() - base) - (pops - p0)), 32'd4);
    a0 = ar_log.size();
    p0 = pops;
    iready = 1'b1;
    tick();
    iready = 1'b0;
    repeat (10) tick();
    check("s2_one_pop", 32'(pops - p0), 32'd1);
    check("s2_one_fetch", 32'(ar_log.size() - a0), 32'd1);
    check_bit("s2_refull", ivalid, 1'b1);

    // Redirect table: flush during DATA with and without the R beat
    r_lat  = 3;
    iready = 1'b1;
    foreach (vecs[i]) begin
      n = 0;
      hit = 1'b0;
      while (!hit && n < 100) begin
        hit = (vecs[i].phase == PH_DATA) ? (rready && !rvalid) : (rready && rvalid);
        if (!hit) begin
          tick();
          n++;
        end
      end
      check_bit("redir_phase_reached", hit, 1'b1);
      idx = ar_log.size();
      p0  = pops;
      redirect    = 1'b1;
      redirect_pc = vecs[i].rd_pc;
      expect_from(vecs[i].exp_pc, 40);
      tick();
      redirect = 1'b0;
      check_bit("redir_flush_ivalid", ivalid, 1'b0);
      wait_pops(p0 + vecs[i].n, 200, "redir_pops");
      check("redir_ar_count", 32'(ar_log.size() > idx), 32'd1);
      if (ar_log.size() > idx) check("redir_araddr", ar_log[idx], vecs[i].exp_pc);
    end

    // Redirect while AR is stalled: old address held, its beat drained, then fetch at new pc
    r_lat    = 1;
    ar_stall = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h5000_0000;
    expect_from(32'h5000_0000, 40);
    tick();
    redirect = 1'b0;
    n = 0;
    while (!(arvalid && !arready) && n < 100) begin
      tick();
      n++;
    end
    check_bit("stall_reached", arvalid && !arready, 1'b1);
    check("stall_araddr", araddr, 32'h5000_0000);
    idx = ar_log.size();
    p0  = pops;
    redirect    = 1'b1;
    redirect_pc = 32'h4000_0001;
    expect_from(32'h4000_0000, 40);
    tick();
    redirect = 1'b0;
    check_bit("stall_flush_ivalid", ivalid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("stall_hold_araddr", araddr, 32'h5000_0000);
      check_bit("stall_hold_arvalid", arvalid, 1'b1);
      tick();
    end
    ar_stall = 1'b0;
    wait_pops(p0 + 3, 200, "stall_pops");
    check("stall_ar_count", 32'(ar_log.size() > idx + 1), 32'd1);
    if (ar_log.size() > idx + 1) begin
      check("stall_old_araddr", ar_log[idx], 32'h5000_0000);
      check("stall_new_araddr", ar_log[idx + 1], 32'h4000_0000);
    end

    // Fault at RESET_PC+8 after a fresh reset: delivered with ifault, then fetch halts
    reset = 1'b1;
    tick();
    tick();
    fault_addr = 32'h3000_0008;
    r_lat      = 0;
    expect_from(RESET_PC, 3);
    base = ar_log.size();
    p0   = pops;
    reset = 1'b0;
    wait_pops(p0 + 3, 100, "fault_pops");
    repeat (10) tick();
    check("fault_ar_count", 32'(ar_log.size() - base), 32'd3);
    check_bit("fault_arvalid", arvalid, 1'b0);
    check_bit("fault_ivalid", ivalid, 1'b0);
`ifdef YSYX_IFU_PERF_EN
    check("perf_fetch", perf_fetch_cnt, 32'd3);
    check("perf_flush0", perf_flush_cnt, 32'd0);
`endif
    p0 = pops;
    redirect    = 1'b1;
    redirect_pc = 32'h3000_0100;
    expect_from(32'h3000_0100, 40);
    tick();
    redirect = 1'b0;
`ifdef YSYX_IFU_PERF_EN
    check("perf_flush1", perf_flush_cnt, 32'd1);
`endif
    wait_pops(p0 + 4, 100, "halt_resume_pops");
    iready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
